// File: rtl/point_scalar_mult_ctl_pkg.sv
// rtl/point_scalar_mult_ctl_pkg.sv - shared defaults, FSM encodings and GF(3) trit helpers
package point_scalar_mult_ctl_pkg;

  localparam int DEF_WIDTH    = 193;
  localparam int DEF_SCALAR_W = 152;
  localparam int DEF_LEN_W    = 8;
  // Field reduction trinomial x^M + x^K + 2 (x^97 + x^12 + 2 at the default width)
  localparam int DEF_F3M_K    = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DBL_GO   = 3'd1,
    ST_DBL_WAIT = 3'd2,
    ST_ADD_GO   = 3'd3,
    ST_ADD_WAIT = 3'd4,
    ST_FIN      = 3'd5
  } ctl_state_e;

  typedef enum logic [2:0] {
    E_START = 3'd0,
    E_SQ    = 3'd1,
    E_INV   = 3'd2,
    E_LAM   = 3'd3,
    E_X     = 3'd4,
    E_Y     = 3'd5,
    E_DONE  = 3'd6
  } eng_state_e;

  typedef enum logic [1:0] {
    SEL_SUM = 2'd0,
    SEL_P1  = 2'd1,
    SEL_P2  = 2'd2,
    SEL_INF = 2'd3
  } eng_sel_e;

  // Trits are coded 2'b00=0, 2'b01=1, 2'b10=2
  function automatic logic [1:0] t_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return (a == b) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] t_neg(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

endpackage

// File: rtl/point_scalar_mult_ctl_point_add.sv
// rtl/point_scalar_mult_ctl_point_add.sv - fixed-latency point add/double on y^2=x^3-x+1 over GF(3^M)
module point_scalar_mult_ctl_point_add
  import point_scalar_mult_ctl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int F3M_K = DEF_F3M_K
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WIDTH:0] x1,
  input  logic [WIDTH:0] y1,
  input  logic           zero1,
  input  logic [WIDTH:0] x2,
  input  logic [WIDTH:0] y2,
  input  logic           zero2,
  output logic           done,
  output logic [WIDTH:0] x3,
  output logic [WIDTH:0] y3,
  output logic           zero3
);

  localparam int M     = (WIDTH + 1) / 2;
  localparam int IDX_W = $clog2(M) + 1;

  typedef logic [WIDTH:0] elem_t;
  localparam elem_t ONE = elem_t'(1);

  function automatic elem_t f3m_add(input elem_t a, input elem_t b);
    elem_t s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i +: 2] = t_add(a[2*i +: 2], b[2*i +: 2]);
    return s;
  endfunction

  function automatic elem_t f3m_neg(input elem_t a);
    elem_t s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i +: 2] = t_neg(a[2*i +: 2]);
    return s;
  endfunction

  function automatic elem_t f3m_sub(input elem_t a, input elem_t b);
    return f3m_add(a, f3m_neg(b));
  endfunction

  function automatic elem_t f3m_mul(input elem_t a, input elem_t b);
    logic [4*M-3:0] p;
    logic [1:0]     t;
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (a[2*i +: 2] != 2'b00) begin
        for (int j = 0; j < M; j++) begin
          if (b[2*j +: 2] != 2'b00)
            p[2*(i+j) +: 2] = t_add(p[2*(i+j) +: 2], t_mul(a[2*i +: 2], b[2*j +: 2]));
        end
      end
    end
    // x^M == 2x^K + 1, folded from the top degree down
    for (int k = 2*M-2; k >= M; k--) begin
      t = p[2*k +: 2];
      if (t != 2'b00) begin
        p[2*(k-M+F3M_K) +: 2] = t_add(p[2*(k-M+F3M_K) +: 2], t_mul(t, 2'b10));
        p[2*(k-M) +: 2]       = t_add(p[2*(k-M) +: 2], t);
        p[2*k +: 2]           = 2'b00;
      end
    end
    return elem_t'(p[2*M-1:0]);
  endfunction

  eng_state_e       st_q;
  eng_sel_e         sel_q;
  logic [IDX_W-1:0] idx_q;
  elem_t            num_q, den_q, den2_q, r_q, lam_q, lx_q;
  elem_t            x3_q, y3_q;
  logic             z3_q, done_q;

  // Every operand pair takes the same path length; special cases only pick the result at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= E_START;
      done_q <= 1'b0;
      x3_q   <= '0;
      y3_q   <= '0;
      z3_q   <= 1'b1;
    end else begin
      unique case (st_q)
        E_START: begin
          if (zero1)                                     sel_q <= SEL_P2;
          else if (zero2)                                sel_q <= SEL_P1;
          else if (x1 == x2 && (y1 != y2 || y1 == '0))   sel_q <= SEL_INF;
          else                                           sel_q <= SEL_SUM;
          if (x1 == x2) begin
            num_q <= ONE;
            den_q <= y1;
          end else begin
            num_q <= f3m_sub(y2, y1);
            den_q <= f3m_sub(x2, x1);
          end
          r_q   <= ONE;
          idx_q <= IDX_W'(M - 1);
          st_q  <= E_SQ;
        end
        E_SQ: begin
          den2_q <= f3m_mul(den_q, den_q);
          st_q   <= E_INV;
        end
        E_INV: begin
          // den^(3^M-2): exponent trits are all 2 except the lowest, which is 1
          r_q <= f3m_mul(f3m_mul(f3m_mul(r_q, r_q), r_q), (idx_q == '0) ? den_q : den2_q);
          if (idx_q == '0) st_q <= E_LAM;
          else             idx_q <= idx_q - 1'b1;
        end
        E_LAM: begin
          lam_q <= f3m_mul(num_q, r_q);
          st_q  <= E_X;
        end
        E_X: begin
          lx_q <= f3m_sub(f3m_mul(lam_q, lam_q), f3m_add(x1, x2));
          st_q <= E_Y;
        end
        E_Y: begin
          unique case (sel_q)
            SEL_P1: begin
              x3_q <= x1;
              y3_q <= y1;
              z3_q <= 1'b0;
            end
            SEL_P2: begin
              x3_q <= zero2 ? '0 : x2;
              y3_q <= zero2 ? '0 : y2;
              z3_q <= zero2;
            end
            SEL_INF: begin
              x3_q <= '0;
              y3_q <= '0;
              z3_q <= 1'b1;
            end
            default: begin
              x3_q <= lx_q;
              y3_q <= f3m_sub(f3m_mul(lam_q, f3m_sub(x1, lx_q)), y1);
              z3_q <= 1'b0;
            end
          endcase
          done_q <= 1'b1;
          st_q   <= E_DONE;
        end
        default: ;
      endcase
    end
  end

  assign done  = done_q;
  assign x3    = x3_q;
  assign y3    = y3_q;
  assign zero3 = z3_q;

endmodule

// File: rtl/point_scalar_mult_ctl.sv
// rtl/point_scalar_mult_ctl.sv - MSB-first double-and-add controller computing (+/-)c*P over GF(3^M)
module point_scalar_mult_ctl
  import point_scalar_mult_ctl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SCALAR_W = DEF_SCALAR_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter bit CT_MODE  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH:0]      x1,
  input  logic [WIDTH:0]      y1,
  input  logic                zero1,
  input  logic [SCALAR_W-1:0] c,
  input  logic [LEN_W-1:0]    len,
  input  logic                neg,
  output logic                busy,
  output logic                done,
  output logic [WIDTH:0]      x3,
  output logic [WIDTH:0]      y3,
  output logic                zero3
);

  localparam int M = (WIDTH + 1) / 2;

  typedef logic [WIDTH:0] elem_t;

  function automatic elem_t f3m_neg(input elem_t a);
    elem_t s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i +: 2] = t_neg(a[2*i +: 2]);
    return s;
  endfunction

  ctl_state_e          state_q;
  elem_t               px_q, py_q, qx_q, qy_q, x3_q, y3_q;
  logic                qz_q, z3_q, neg_q, busy_q, done_q, eng_rst_q;
  logic [SCALAR_W-1:0] c_q, c_shift;
  logic [LEN_W-1:0]    b_q, n_in;
  logic                c_bit, add_phase;
  elem_t               eng_x2, eng_y2, eng_x3, eng_y3;
  logic                eng_z2, eng_z3, eng_done;

  always_comb begin
    n_in      = (len > LEN_W'(SCALAR_W)) ? LEN_W'(SCALAR_W) : len;
    c_shift   = c_q >> b_q;
    c_bit     = c_shift[0];
    add_phase = (state_q == ST_ADD_GO) || (state_q == ST_ADD_WAIT);
    // P is always finite while adding: an infinite base point skips straight to FIN
    eng_x2    = add_phase ? px_q : qx_q;
    eng_y2    = add_phase ? py_q : qy_q;
    eng_z2    = add_phase ? 1'b0 : qz_q;
  end

  point_scalar_mult_ctl_point_add #(
    .WIDTH (WIDTH)
  ) u_point_add (
    .clk   (clk),
    .reset (eng_rst_q),
    .x1    (qx_q),
    .y1    (qy_q),
    .zero1 (qz_q),
    .x2    (eng_x2),
    .y2    (eng_y2),
    .zero2 (eng_z2),
    .done  (eng_done),
    .x3    (eng_x3),
    .y3    (eng_y3),
    .zero3 (eng_z3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x3_q      <= '0;
      y3_q      <= '0;
      z3_q      <= 1'b1;
      qx_q      <= '0;
      qy_q      <= '0;
      qz_q      <= 1'b1;
      eng_rst_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          eng_rst_q <= 1'b1;
          if (start) begin
            px_q   <= x1;
            py_q   <= y1;
            c_q    <= c;
            neg_q  <= neg;
            qx_q   <= '0;
            qy_q   <= '0;
            qz_q   <= 1'b1;
            busy_q <= 1'b1;
            if (n_in == '0 || zero1) begin
              state_q <= ST_FIN;
            end else begin
              b_q     <= n_in - 1'b1;
              state_q <= ST_DBL_GO;
            end
          end
        end
        ST_DBL_GO: begin
          eng_rst_q <= 1'b0;
          state_q   <= ST_DBL_WAIT;
        end
        ST_DBL_WAIT: begin
          if (eng_done) begin
            qx_q      <= eng_x3;
            qy_q      <= eng_y3;
            qz_q      <= eng_z3;
            eng_rst_q <= 1'b1;
            if (c_bit || CT_MODE)  state_q <= ST_ADD_GO;
            else if (b_q == '0)    state_q <= ST_FIN;
            else begin
              b_q     <= b_q - 1'b1;
              state_q <= ST_DBL_GO;
            end
          end
        end
        ST_ADD_GO: begin
          eng_rst_q <= 1'b0;
          state_q   <= ST_ADD_WAIT;
        end
        ST_ADD_WAIT: begin
          if (eng_done) begin
            if (c_bit) begin
              qx_q <= eng_x3;
              qy_q <= eng_y3;
              qz_q <= eng_z3;
            end
            eng_rst_q <= 1'b1;
            if (b_q == '0) state_q <= ST_FIN;
            else begin
              b_q     <= b_q - 1'b1;
              state_q <= ST_DBL_GO;
            end
          end
        end
        ST_FIN: begin
          x3_q    <= qz_q ? '0 : qx_q;
          y3_q    <= qz_q ? '0 : (neg_q ? f3m_neg(qy_q) : qy_q);
          z3_q    <= qz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x3    = x3_q;
  assign y3    = y3_q;
  assign zero3 = z3_q;

endmodule

// File: tb/tb_point_scalar_mult_ctl.sv
// tb/tb_point_scalar_mult_ctl.sv - bench for point_scalar_mult_ctl against a cyclic-group model of <P>
module tb_point_scalar_mult_ctl;

  localparam int W     = 193;
  localparam int SW    = 152;
  localparam int LW    = 8;
  localparam int LIMIT = 5000;

  typedef logic [W:0] elem_t;

  logic          clk = 1'b0;
  logic          reset, start, zero1, neg;
  elem_t         x1, y1;
  logic [SW-1:0] c;
  logic [LW-1:0] len;

  logic  busy_a, done_a, z_a, busy_b, done_b, z_b;
  elem_t xa, ya, xb, yb;

  int total = 0;
  int bad   = 0;

  // k*P for P=(0,1), group order 7; index 0 is infinity
  int px[7] = '{0, 0, 1, 2, 2, 1, 0};
  int py[7] = '{0, 1, 1, 2, 1, 2, 2};

  elem_t rxa, rya, rxb, ryb;
  logic  rza, rzb;
  int    lat_a, lat_b;

  always #5 clk = ~clk;

  point_scalar_mult_ctl #(.WIDTH(W), .SCALAR_W(SW), .LEN_W(LW), .CT_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .x1(x1), .y1(y1), .zero1(zero1),
    .c(c), .len(len), .neg(neg), .busy(busy_a), .done(done_a),
    .x3(xa), .y3(ya), .zero3(z_a)
  );

  point_scalar_mult_ctl #(.WIDTH(W), .SCALAR_W(SW), .LEN_W(LW), .CT_MODE(1'b1)) dut_ct (
    .clk(clk), .reset(reset), .start(start), .x1(x1), .y1(y1), .zero1(zero1),
    .c(c), .len(len), .neg(neg), .busy(busy_b), .done(done_b),
    .x3(xb), .y3(yb), .zero3(z_b)
  );

  task automatic check(input string tag, input elem_t obs, input elem_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [SW-1:0] cv, input int n, input bit nv, input int k);
    int r;
    r = 0;
    for (int i = n - 1; i >= 0; i--) r = (2 * r + int'(cv[i])) % 7;
    r = (r * k) % 7;
    if (nv) r = (7 - r) % 7;
    return r;
  endfunction

  task automatic check_result(input string tag, input int r);
    check({tag, "_x"},    rxa, elem_t'(px[r]));
    check({tag, "_y"},    rya, elem_t'(py[r]));
    check({tag, "_z"},    elem_t'(rza), elem_t'(r == 0));
    check({tag, "_ct_x"}, rxb, elem_t'(px[r]));
    check({tag, "_ct_y"}, ryb, elem_t'(py[r]));
    check({tag, "_ct_z"}, elem_t'(rzb), elem_t'(r == 0));
  endtask

  // Starts one operation on both instances; pulse_at > 0 re-pulses start mid-run with other operands.
  task automatic do_op(input logic [SW-1:0] cv, input logic [LW-1:0] lv, input logic nv,
                       input int k, input int pulse_at);
    bit got_a, got_b;
    @(negedge clk);
    c     = cv;
    len   = lv;
    neg   = nv;
    zero1 = (k == 0);
    x1    = (k == 0) ? elem_t'($urandom) : elem_t'(px[k]);
    y1    = (k == 0) ? elem_t'($urandom) : elem_t'(py[k]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_a = 1'b0;
    got_b = 1'b0;
    lat_a = -1;
    lat_b = -1;
    for (int cyc = 1; cyc <= LIMIT && !(got_a && got_b); cyc++) begin
      if (done_a && !got_a) begin
        got_a = 1'b1; lat_a = cyc; rxa = xa; rya = ya; rza = z_a;
      end
      if (done_b && !got_b) begin
        got_b = 1'b1; lat_b = cyc; rxb = xb; ryb = yb; rzb = z_b;
      end
      if (!(got_a && got_b)) begin
        start = (cyc == pulse_at);
        if (cyc == pulse_at) begin
          c = 1; len = 1; neg = ~nv; x1 = elem_t'(2); y1 = elem_t'(2); zero1 = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    total++;
    assert (got_a && got_b) else begin
      bad++;
      $error("FAIL op_timeout observed done_a=%0b done_b=%0b expected both", got_a, got_b);
    end
  endtask

  initial begin
    int lat1, lat8, n, k, r, saw;
    logic [159:0]  rnd;
    logic [SW-1:0] cv;
    logic [LW-1:0] lv;
    bit            nv;

    reset = 1'b1; start = 1'b0; zero1 = 1'b0; neg = 1'b0;
    x1 = '0; y1 = '0; c = '0; len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  elem_t'(busy_a), elem_t'(0));
    check("rst_done",  elem_t'(done_a), elem_t'(0));
    check("rst_x3",    xa, elem_t'(0));
    check("rst_y3",    ya, elem_t'(0));
    check("rst_zero3", elem_t'(z_a), elem_t'(1));
    check("rst_ct_zero3", elem_t'(z_b), elem_t'(1));
    reset = 1'b0;

    do_op(1, 1, 1'b0, 1, 0);
    check_result("c1_len1", 1);
    lat1 = lat_a;

    do_op(3, 2, 1'b0, 1, 0);
    check_result("c3_len2", 3);
    do_op(3, 2, 1'b1, 1, 0);
    check_result("c3_len2_neg", 4);

    do_op(7, 3, 1'b0, 1, 0);
    check_result("c7_len3", 0);
    do_op(7, 3, 1'b1, 1, 0);
    check_result("c7_len3_neg", 0);

    do_op(5, 0, 1'b0, 1, 0);
    check_result("len0", 0);
    check("len0_lat",    elem_t'(lat_a), elem_t'(2));
    check("len0_ct_lat", elem_t'(lat_b), elem_t'(2));

    do_op(5, 3, 1'b0, 0, 0);
    check_result("p_inf", 0);
    check("p_inf_lat", elem_t'(lat_a), elem_t'(2));

    do_op('h1F, 2, 1'b0, 1, 0);
    check_result("c1f_len2", 3);

    do_op(8, 4, 1'b0, 1, 0);
    check_result("ct_c8", 1);
    lat8 = lat_b;
    do_op(15, 4, 1'b0, 1, 0);
    check_result("ct_c15", 1);
    check("ct_equal_cycles", elem_t'(lat_b), elem_t'(lat8));

    for (int it = 0; it < 12; it++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cv  = rnd[SW-1:0];
      lv  = LW'($urandom_range(0, 8));
      nv  = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 6);
      n   = (int'(lv) > SW) ? SW : int'(lv);
      r   = model_idx(cv, n, nv, k);
      do_op(cv, lv, nv, k, 0);
      check_result($sformatf("rnd%0d", it), r);
    end

    @(negedge clk);
    c = 3; len = 2; neg = 1'b0; zero1 = 1'b0; x1 = elem_t'(0); y1 = elem_t'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (lat1 * 3 / 4) @(negedge clk);
    check("abort_busy_before", elem_t'(busy_a), elem_t'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",  elem_t'(busy_a), elem_t'(0));
    check("abort_done",  elem_t'(done_a), elem_t'(0));
    check("abort_zero3", elem_t'(z_a), elem_t'(1));
    check("abort_x3",    xa, elem_t'(0));
    check("abort_y3",    ya, elem_t'(0));
    check("abort_ct_busy", elem_t'(busy_b), elem_t'(0));
    saw = 0;
    repeat (lat1 * 2) begin
      @(negedge clk);
      if (done_a || done_b) saw = 1;
    end
    check("abort_no_done", elem_t'(saw), elem_t'(0));

    do_op(2, 2, 1'b0, 1, 10);
    check_result("after_abort_c2", 2);
    saw = 0;
    repeat (lat1 + 20) begin
      @(negedge clk);
      if (done_a || done_b) saw = 1;
    end
    check("busy_start_ignored", elem_t'(saw), elem_t'(0));
    check("idle_busy", elem_t'(busy_a), elem_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
